// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial frame front end.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    RECV  = 3'd2,
    STOP  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  // Sliced down to the cntout width; all-ones tells the buffer "no frame".
  localparam logic [31:0] CNT_IDLE = 32'hFFFF_FFFF;

  function automatic int clog2_w(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/rx_sync_edge.sv
// Two-flop synchronizer for the serial line plus a falling-edge detector
// on the synchronized level.
module rx_sync_edge
  import serial_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  output logic level,
  output logic fall
);

  logic s1;
  logic s2;
  logic s2_prev;

  // Idle line is high, so reset to 1 keeps a reset release from faking an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1      <= 1'b1;
      s2      <= 1'b1;
      s2_prev <= 1'b1;
    end else begin
      s1      <= rxd;
      s2      <= s1;
      s2_prev <= s2;
    end
  end

  assign level = s2;
  assign fall  = s2_prev & ~s2;

endmodule

// File: rtl/serial_frame_ctrl.sv
// Oversampling serial receiver: recovers NDATA bits, strobes each out on
// ena, then drains cntout 0..NDATA-1 to the capture buffer after a good stop.
module serial_frame_ctrl
  import serial_pkg::*;
#(
  parameter int NDATA = 128,
  parameter int OVS   = 8,
  localparam int NDATA_LOG = clog2_w(NDATA),
  localparam int OVS_LOG   = clog2_w(OVS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic                 en,
  output logic                 dout,
  output logic                 ena,
  output logic [NDATA_LOG-1:0] cntout,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 frame_err
);

  localparam logic [NDATA_LOG-1:0] CNT_ONES = CNT_IDLE[NDATA_LOG-1:0];
  localparam logic [NDATA_LOG-1:0] CNT_LAST = NDATA_LOG'(NDATA - 1);
  localparam logic [NDATA_LOG-1:0] CNT_PRE  = NDATA_LOG'(NDATA - 2);
  localparam logic [OVS_LOG-1:0]   OS_MID   = OVS_LOG'(OVS / 2 - 1);
  localparam logic [OVS_LOG-1:0]   OS_LAST  = OVS_LOG'(OVS - 1);
  localparam logic [NDATA_LOG:0]   BIT_LAST = (NDATA_LOG + 1)'(NDATA - 1);

  logic level;
  logic fall;

  rx_sync_edge u_sync (
    .clk   (clk),
    .rst   (rst),
    .rxd   (rxd),
    .level (level),
    .fall  (fall)
  );

  state_t                 state;
  state_t                 state_n;
  logic [OVS_LOG-1:0]     os_cnt;
  logic [OVS_LOG-1:0]     os_n;
  logic [NDATA_LOG:0]     bit_cnt;
  logic [NDATA_LOG:0]     bit_n;
  logic                   dout_n;
  logic                   ena_n;
  logic [NDATA_LOG-1:0]   cnt_n;
  logic                   done_n;
  logic                   err_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      os_cnt     <= '0;
      bit_cnt    <= '0;
      dout       <= 1'b0;
      ena        <= 1'b0;
      cntout     <= CNT_ONES;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      os_cnt     <= os_n;
      bit_cnt    <= bit_n;
      dout       <= dout_n;
      ena        <= ena_n;
      cntout     <= cnt_n;
      frame_done <= done_n;
      frame_err  <= err_n;
    end
  end

  // Outputs are registered; every branch below sets the value for the next cycle.
  always_comb begin
    state_n = state;
    os_n    = os_cnt;
    bit_n   = bit_cnt;
    dout_n  = dout;
    ena_n   = 1'b0;
    cnt_n   = CNT_ONES;
    done_n  = 1'b0;
    err_n   = 1'b0;

    if (!en) begin
      state_n = IDLE;
      os_n    = '0;
      bit_n   = '0;
      dout_n  = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (fall) begin
            state_n = START;
            os_n    = '0;
          end
        end

        START: begin
          if (os_cnt == OS_MID) begin
            os_n = '0;
            if (!level) begin
              state_n = RECV;
              bit_n   = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            os_n = os_cnt + 1'b1;
          end
        end

        RECV: begin
          if (os_cnt == OS_LAST) begin
            os_n   = '0;
            dout_n = level;
            ena_n  = 1'b1;
            bit_n  = bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
              state_n = STOP;
            end
          end else begin
            os_n = os_cnt + 1'b1;
          end
        end

        // One full bit period after the last data sample lands on mid-stop.
        STOP: begin
          if (os_cnt == OS_LAST) begin
            os_n = '0;
            if (level) begin
              state_n = DRAIN;
              cnt_n   = '0;
            end else begin
              state_n = IDLE;
              err_n   = 1'b1;
            end
          end else begin
            os_n = os_cnt + 1'b1;
          end
        end

        // frame_done is raised on the edge that loads NDATA-1 so both appear together.
        DRAIN: begin
          if (cntout == CNT_LAST) begin
            state_n = IDLE;
          end else begin
            cnt_n = cntout + 1'b1;
            if (cntout == CNT_PRE) begin
              done_n = 1'b1;
            end
          end
        end

        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Randomized scoreboard bench for serial_frame_ctrl with NDATA=8, OVS=4.
module tb_serial_frame_ctrl;

  localparam int NDATA = 8;
  localparam int OVS   = 4;
  localparam int NLOG  = $clog2(NDATA);
  localparam int ONES  = (1 << NLOG) - 1;
  localparam int EV_NONE = 0;
  localparam int EV_DONE = 1;
  localparam int EV_ERR  = 2;

  logic            clk;
  logic            rst;
  logic            rxd;
  logic            en;
  logic            dout;
  logic            ena;
  logic [NLOG-1:0] cntout;
  logic            busy;
  logic            frame_done;
  logic            frame_err;

  serial_frame_ctrl #(.NDATA(NDATA), .OVS(OVS)) dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .en         (en),
    .dout       (dout),
    .ena        (ena),
    .cntout     (cntout),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  typedef struct {
    logic val;
    int   idx;
  } bit_exp_t;

  bit_exp_t exp_bits[$];
  int       exp_evt[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ena_total = 0;
  int err_total = 0;
  int done_total = 0;
  int done_issued = 0;
  int last_ena_cyc = -1000;
  bit in_drain = 0;
  int drain_idx = 0;
  bit prev_done = 0;
  bit prev_ena = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at cycle %0d", name, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a strobe or pulse.
  always @(negedge clk) begin
    int got;
    bit_exp_t e;
    if (!rst) begin
      in_drain  = 0;
      prev_done = 0;
      prev_ena  = 0;
    end else begin
      if (ena) begin
        ena_total++;
        check("ena_width", int'(prev_ena), 0);
        if (exp_bits.size() == 0) begin
          check("ena_unexpected", 1, 0);
        end else begin
          e = exp_bits.pop_front();
          check("dout_bit", int'(dout), int'(e.val));
          if (e.idx > 0) check("ena_spacing", cyc - last_ena_cyc, OVS);
        end
        last_ena_cyc = cyc;
      end

      if (in_drain) begin
        drain_idx++;
        check("drain_cntout", int'(cntout), drain_idx);
        check("drain_busy", int'(busy), 1);
        check("drain_ena", int'(ena), 0);
        check("drain_done_pos", int'(frame_done), (drain_idx == NDATA - 1) ? 1 : 0);
        if (drain_idx == NDATA - 1) in_drain = 0;
      end else if (int'(cntout) != ONES) begin
        check("drain_first", int'(cntout), 0);
        check("drain_gap_ge_ovs", (cyc - last_ena_cyc >= OVS) ? 1 : 0, 1);
        check("drain_first_done", int'(frame_done), 0);
        in_drain  = 1;
        drain_idx = 0;
      end else begin
        check("idle_done", int'(frame_done), 0);
      end

      if (prev_done) check("busy_after_done", int'(busy), 0);

      if (frame_done || frame_err) begin
        got = frame_done ? EV_DONE : EV_ERR;
        if (frame_err) begin
          err_total++;
          check("err_cntout", int'(cntout), ONES);
        end
        if (frame_done) done_total++;
        if (exp_evt.size() == 0) check("event_unexpected", got, EV_NONE);
        else check("frame_event", got, exp_evt.pop_front());
      end

      prev_done = frame_done;
      prev_ena  = ena;
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_dout"}, int'(dout), 0);
    check({tag, "_ena"}, int'(ena), 0);
    check({tag, "_cntout"}, int'(cntout), ONES);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(frame_done), 0);
    check({tag, "_err"}, int'(frame_err), 0);
  endtask

  // abort_kind: 1 = async reset, 2 = drop en; applied once abort_after strobes were seen.
  task automatic do_abort(input int abort_kind);
    exp_bits.delete();
    exp_evt.delete();
    rxd = 1'b1;
    if (abort_kind == 1) begin
      rst = 1'b0;
      #1;
      check_reset_vals("abort_rst");
      step();
      step();
      rst = 1'b1;
    end else begin
      en = 1'b0;
      step();
      check_reset_vals("abort_en");
      step();
      step();
      en = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [NDATA-1:0] data, input bit stop,
                            input int abort_after, input int abort_kind);
    logic [NDATA+1:0] line;
    int  base;
    bit  aborted;
    line = {stop, data, 1'b0};
    base = ena_total;
    for (int k = 0; k < NDATA; k++) exp_bits.push_back('{val: data[k], idx: k});
    exp_evt.push_back(stop ? EV_DONE : EV_ERR);
    aborted = 0;
    for (int b = 0; b < NDATA + 2 && !aborted; b++) begin
      rxd = line[b];
      for (int c = 0; c < OVS && !aborted; c++) begin
        step();
        if (abort_after > 0 && ena_total - base == abort_after) begin
          aborted = 1;
          do_abort(abort_kind);
        end
      end
    end
    rxd = 1'b1;
    if (!aborted && stop) done_issued++;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  initial begin
    int base_ena;
    int base_err;
    bit saw_busy;
    rst = 1'b0;
    en  = 1'b1;
    rxd = 1'b1;
    repeat (3) step();
    check_reset_vals("reset");
    rst = 1'b1;
    idle(3);

    send_frame(8'hA5, 1'b1, 0, 0);
    idle(14);
    send_frame(8'h5A, 1'b0, 0, 0);
    idle(14);

    base_ena = ena_total;
    base_err = err_total;
    saw_busy = 0;
    rxd = 1'b0;
    step();
    rxd = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (busy) saw_busy = 1;
    end
    check("glitch_start", int'(saw_busy), 1);
    check("glitch_ena", ena_total - base_ena, 0);
    check("glitch_err", err_total - base_err, 0);
    check("glitch_busy", int'(busy), 0);

    send_frame(8'hC3, 1'b1, 3, 1);
    idle(10);
    send_frame(8'h3C, 1'b1, 0, 0);
    idle(14);

    send_frame(8'h96, 1'b1, 4, 2);
    idle(10);
    send_frame(8'h81, 1'b1, 0, 0);
    idle(14);

    base_ena = ena_total;
    send_frame(8'h7E, 1'b1, 0, 0);
    idle(2);
    rxd = 1'b0;
    idle(2);
    rxd = 1'b1;
    idle(14);
    check("drain_edge_ena", ena_total - base_ena, NDATA);
    check("drain_edge_busy", int'(busy), 0);

    for (int f = 0; f < 20; f++) begin
      send_frame(NDATA'($urandom), ($urandom_range(0, 4) != 0), 0, 0);
      idle($urandom_range(12, 20));
    end

    check("bits_left", exp_bits.size(), 0);
    check("events_left", exp_evt.size(), 0);
    check("frames_done", done_total, done_issued);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    repeat (30000) @(posedge clk);
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
